ddr_weight_pingpong_ctrl: RTL and testbench

- Schedules DDR3 weight bursts into the two 64-entry, 256-bit synapse-weight FIFOs and drives their write/read ping-pong selects.
- The write side issues one AXI read burst per tile into whichever FIFO is empty.
- The read side tracks consumption by the synapse datapath and flips the read buffer when a tile is fully drained.
- Sits between the AXI DDR3 read-channel master, the weight FIFO pair and the core controller.

---
 rtl/ddr_weight_pingpong_ctrl_pkg.sv | 20 ++
 rtl/weight_tile_counter.sv | 28 ++
 rtl/ddr_weight_pingpong_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ddr_weight_pingpong_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_weight_pingpong_ctrl_pkg.sv
// rtl/ddr_weight_pingpong_ctrl_pkg.sv - shared types and constants for the weight ping-pong controller
package ddr_weight_pingpong_ctrl_pkg;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_CHECK = 2'd1,
        W_REQ   = 2'd2,
        W_DATA  = 2'd3
    } w_state_t;

    localparam int BURST_BEATS_DEF = 64;
    localparam int BEAT_BYTES_DEF  = 32;
    localparam int TILE_STRIDE     = BURST_BEATS_DEF * BEAT_BYTES_DEF;

    // Byte distance between consecutive tiles in DDR.
    function automatic int tile_stride(input int beats, input int bytes);
        return beats * bytes;
    endfunction

endpackage

// File: rtl/weight_tile_counter.sv
// rtl/weight_tile_counter.sv - beat counter that wraps and pulses tc on its final beat
module weight_tile_counter #(
    parameter int COUNT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int W = (COUNT > 2) ? $clog2(COUNT) : 1;

    logic [W-1:0] count;

    assign tc = inc & (count == W'(COUNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/ddr_weight_pingpong_ctrl.sv
// rtl/ddr_weight_pingpong_ctrl.sv - schedules DDR weight bursts into a ping-pong FIFO pair
module ddr_weight_pingpong_ctrl
    import ddr_weight_pingpong_ctrl_pkg::*;
#(
    parameter int DDR_ADDR_WIDTH = 32,
    parameter int BURST_BEATS    = BURST_BEATS_DEF,
    parameter int BEAT_BYTES     = BEAT_BYTES_DEF,
    parameter int TILE_CNT_WIDTH = 10,
    parameter int LEN_WIDTH      = 8
) (
    input  logic                      CLK,
    input  logic                      RSTN_syncn,
    input  logic                      START,
    input  logic [DDR_ADDR_WIDTH-1:0] BASE_ADDR,
    input  logic [TILE_CNT_WIDTH-1:0] TILE_NUM,
    output logic                      RD_REQ,
    output logic [DDR_ADDR_WIDTH-1:0] RD_ADDR,
    output logic [LEN_WIDTH-1:0]      RD_LEN,
    input  logic                      RD_ACK,
    input  logic                      RD_FIFO_WE,
    input  logic                      CTRL_ADDR1_READ,
    output logic                      FIFO_Write_Choose,
    output logic                      FIFO_Read_Choose,
    output logic                      TILE_READY,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      ERR
);

    localparam logic [DDR_ADDR_WIDTH-1:0] STRIDE =
        DDR_ADDR_WIDTH'(tile_stride(BURST_BEATS, BEAT_BYTES));

    w_state_t                  state, state_nxt;
    logic                      busy, done, err, wsel, rsel;
    logic [1:0]                buf_full, set_mask, clr_mask;
    logic [DDR_ADDR_WIDTH-1:0] cur_addr;
    logic [TILE_CNT_WIDTH-1:0] tile_num, tiles_issued, tiles_consumed;
    logic                      start_acc, wr_beat, wr_tc, rd_pop, rd_tc, tile_ready;
    logic                      stray_beat, underrun;

    assign start_acc  = START & ~busy;
    assign tile_ready = busy & buf_full[rsel];
    assign wr_beat    = RD_FIFO_WE & (state == W_DATA);
    assign rd_pop     = CTRL_ADDR1_READ & tile_ready;
    // Stray beats only count as errors once a layer owns the FIFOs again.
    assign stray_beat = RD_FIFO_WE & (state != W_DATA) & busy;
    assign underrun   = CTRL_ADDR1_READ & ~tile_ready;

    assign set_mask = {wr_tc & wsel, wr_tc & ~wsel};
    assign clr_mask = {rd_tc & rsel, rd_tc & ~rsel};

    weight_tile_counter #(.COUNT(BURST_BEATS)) u_wr_cnt (
        .clk   (CLK),
        .rst_n (RSTN_syncn),
        .clr   (start_acc),
        .inc   (wr_beat),
        .tc    (wr_tc)
    );

    weight_tile_counter #(.COUNT(BURST_BEATS)) u_rd_cnt (
        .clk   (CLK),
        .rst_n (RSTN_syncn),
        .clr   (start_acc),
        .inc   (rd_pop),
        .tc    (rd_tc)
    );

    always_ff @(posedge CLK or negedge RSTN_syncn) begin
        if (!RSTN_syncn) begin
            state <= W_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        RD_REQ    = 1'b0;
        RD_ADDR   = '0;
        RD_LEN    = '0;
        case (state)
            W_IDLE: begin
                if (start_acc && (TILE_NUM != '0)) begin
                    state_nxt = W_CHECK;
                end
            end
            W_CHECK: begin
                if (tiles_issued == tile_num) begin
                    state_nxt = W_IDLE;
                end else if (!buf_full[wsel]) begin
                    state_nxt = W_REQ;
                end
            end
            W_REQ: begin
                RD_REQ  = 1'b1;
                RD_ADDR = cur_addr;
                RD_LEN  = LEN_WIDTH'(BURST_BEATS - 1);
                if (RD_ACK) begin
                    state_nxt = W_DATA;
                end
            end
            W_DATA: begin
                if (wr_tc) begin
                    state_nxt = W_CHECK;
                end
            end
            default: state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN_syncn) begin
        if (!RSTN_syncn) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            wsel           <= 1'b0;
            rsel           <= 1'b0;
            buf_full       <= '0;
            cur_addr       <= '0;
            tile_num       <= '0;
            tiles_issued   <= '0;
            tiles_consumed <= '0;
        end else begin
            done <= 1'b0;
            if (start_acc) begin
                tile_num       <= TILE_NUM;
                cur_addr       <= BASE_ADDR;
                tiles_issued   <= '0;
                tiles_consumed <= '0;
                buf_full       <= '0;
                wsel           <= 1'b0;
                rsel           <= 1'b0;
                err            <= 1'b0;
                busy           <= (TILE_NUM != '0);
                done           <= (TILE_NUM == '0);
            end else begin
                if (wr_tc) begin
                    cur_addr     <= cur_addr + STRIDE;
                    tiles_issued <= tiles_issued + 1'b1;
                    wsel         <= ~wsel;
                end
                if (rd_tc) begin
                    rsel           <= ~rsel;
                    tiles_consumed <= tiles_consumed + 1'b1;
                    if (tiles_consumed + 1'b1 == tile_num) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                // Ownership rules keep set and clear on different bits.
                buf_full <= (buf_full | set_mask) & ~clr_mask;
                if (stray_beat || underrun) begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign FIFO_Write_Choose = wsel;
    assign FIFO_Read_Choose  = rsel;
    assign TILE_READY        = tile_ready;
    assign BUSY              = busy;
    assign DONE              = done;
    assign ERR               = err;

endmodule

// File: tb/tb_ddr_weight_pingpong_ctrl.sv
// tb/tb_ddr_weight_pingpong_ctrl.sv - directed self-checking bench for ddr_weight_pingpong_ctrl
module tb_ddr_weight_pingpong_ctrl;

    logic        CLK;
    logic        RSTN_syncn;
    logic        START;
    logic [31:0] BASE_ADDR;
    logic [9:0]  TILE_NUM;
    logic        RD_REQ;
    logic [31:0] RD_ADDR;
    logic [7:0]  RD_LEN;
    logic        RD_ACK;
    logic        RD_FIFO_WE;
    logic        CTRL_ADDR1_READ;
    logic        FIFO_Write_Choose;
    logic        FIFO_Read_Choose;
    logic        TILE_READY;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    int total = 0;
    int bad   = 0;
    logic flag;

    ddr_weight_pingpong_ctrl dut (
        .CLK               (CLK),
        .RSTN_syncn        (RSTN_syncn),
        .START             (START),
        .BASE_ADDR         (BASE_ADDR),
        .TILE_NUM          (TILE_NUM),
        .RD_REQ            (RD_REQ),
        .RD_ADDR           (RD_ADDR),
        .RD_LEN            (RD_LEN),
        .RD_ACK            (RD_ACK),
        .RD_FIFO_WE        (RD_FIFO_WE),
        .CTRL_ADDR1_READ   (CTRL_ADDR1_READ),
        .FIFO_Write_Choose (FIFO_Write_Choose),
        .FIFO_Read_Choose  (FIFO_Read_Choose),
        .TILE_READY        (TILE_READY),
        .BUSY              (BUSY),
        .DONE              (DONE),
        .ERR               (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic [31:0] base, input logic [9:0] n);
        START     = 1'b1;
        BASE_ADDR = base;
        TILE_NUM  = n;
        tick();
        START = 1'b0;
    endtask

    task automatic burst(input string tag, input logic [31:0] addr, input bit with_reads);
        chk({tag, "_req"}, RD_REQ, 1'b1);
        chk({tag, "_addr"}, RD_ADDR, addr);
        chk({tag, "_len"}, RD_LEN, 8'd63);
        RD_ACK = 1'b1;
        tick();
        RD_ACK = 1'b0;
        chk({tag, "_req_drop"}, RD_REQ, 1'b0);
        for (int i = 0; i < 64; i++) begin
            RD_FIFO_WE      = 1'b1;
            CTRL_ADDR1_READ = with_reads;
            tick();
        end
        RD_FIFO_WE      = 1'b0;
        CTRL_ADDR1_READ = 1'b0;
    endtask

    task automatic reads(input int n);
        for (int i = 0; i < n; i++) begin
            CTRL_ADDR1_READ = 1'b1;
            tick();
        end
        CTRL_ADDR1_READ = 1'b0;
    endtask

    initial begin
        RSTN_syncn      = 1'b0;
        START           = 1'b0;
        BASE_ADDR       = '0;
        TILE_NUM        = '0;
        RD_ACK          = 1'b0;
        RD_FIFO_WE      = 1'b0;
        CTRL_ADDR1_READ = 1'b0;
        tick(); tick(); tick();
        chk("rst_req",   RD_REQ, 1'b0);
        chk("rst_addr",  RD_ADDR, 32'h0);
        chk("rst_len",   RD_LEN, 8'h0);
        chk("rst_busy",  BUSY, 1'b0);
        chk("rst_done",  DONE, 1'b0);
        chk("rst_err",   ERR, 1'b0);
        chk("rst_ready", TILE_READY, 1'b0);
        chk("rst_sel",   {FIFO_Write_Choose, FIFO_Read_Choose}, 2'b00);
        RSTN_syncn = 1'b1;
        tick();

        // Three tiles, consumer reading alongside later bursts
        do_start(32'h1000, 10'd3);
        chk("s1_busy", BUSY, 1'b1);
        chk("s1_req_lat1", RD_REQ, 1'b0);
        tick();
        chk("s1_wsel0", FIFO_Write_Choose, 1'b0);
        burst("s1_b0", 32'h1000, 1'b0);
        chk("s1_ready0", TILE_READY, 1'b1);
        chk("s1_wsel1", FIFO_Write_Choose, 1'b1);
        tick();
        burst("s1_b1", 32'h1800, 1'b1);
        chk("s1_rsel1", FIFO_Read_Choose, 1'b1);
        chk("s1_ready1", TILE_READY, 1'b1);
        chk("s1_wsel2", FIFO_Write_Choose, 1'b0);
        tick();
        burst("s1_b2", 32'h2000, 1'b1);
        chk("s1_rsel2", FIFO_Read_Choose, 1'b0);
        chk("s1_ready2", TILE_READY, 1'b1);
        tick();
        chk("s1_no_req", RD_REQ, 1'b0);
        reads(64);
        chk("s1_done", DONE, 1'b1);
        chk("s1_busy_off", BUSY, 1'b0);
        chk("s1_rsel_end", FIFO_Read_Choose, 1'b1);
        chk("s1_err", ERR, 1'b0);
        tick();
        chk("s1_done_pulse", DONE, 1'b0);

        // Empty layer
        do_start(32'h3000, 10'd0);
        chk("s5_done", DONE, 1'b1);
        chk("s5_busy", BUSY, 1'b0);
        flag = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            flag = flag | RD_REQ | BUSY | DONE;
        end
        chk("s5_quiet", flag, 1'b0);

        // Underrun before first tile completes
        do_start(32'hA000, 10'd1);
        CTRL_ADDR1_READ = 1'b1;
        tick();
        CTRL_ADDR1_READ = 1'b0;
        chk("s3_err", ERR, 1'b1);
        burst("s3_b0", 32'hA000, 1'b0);
        reads(63);
        chk("s3_rsel_63", FIFO_Read_Choose, 1'b0);
        chk("s3_ready_63", TILE_READY, 1'b1);
        reads(1);
        chk("s3_rsel_64", FIFO_Read_Choose, 1'b1);
        chk("s3_done", DONE, 1'b1);
        chk("s3_err_sticky", ERR, 1'b1);

        // Stray write beat while writer is idle but layer still busy
        do_start(32'hC000, 10'd1);
        chk("s4_err_clr", ERR, 1'b0);
        tick();
        burst("s4_b0", 32'hC000, 1'b0);
        tick();
        RD_FIFO_WE = 1'b1;
        tick();
        RD_FIFO_WE = 1'b0;
        chk("s4_err", ERR, 1'b1);
        chk("s4_wsel", FIFO_Write_Choose, 1'b1);
        chk("s4_ready", TILE_READY, 1'b1);
        reads(64);
        chk("s4_done", DONE, 1'b1);
        chk("s4_ready_end", TILE_READY, 1'b0);

        // Stalled consumer: lookahead limited to two tiles
        do_start(32'h4000, 10'd4);
        tick();
        burst("s2_b0", 32'h4000, 1'b0);
        tick();
        burst("s2_b1", 32'h4800, 1'b0);
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                START     = 1'b1;
                BASE_ADDR = 32'hF000;
                TILE_NUM  = 10'd2;
            end
            tick();
            START = 1'b0;
            flag  = flag | RD_REQ;
        end
        chk("s2_no_third", flag, 1'b0);
        chk("s2_ready", TILE_READY, 1'b1);
        reads(64);
        chk("s2_rsel", FIFO_Read_Choose, 1'b1);
        tick();
        chk("s2_b2_req", RD_REQ, 1'b1);
        chk("s2_b2_addr", RD_ADDR, 32'h5000);

        // Asynchronous reset at beat 30 of the third tile
        RD_ACK = 1'b1;
        tick();
        RD_ACK = 1'b0;
        for (int i = 0; i < 30; i++) begin
            RD_FIFO_WE = 1'b1;
            tick();
        end
        RSTN_syncn = 1'b0;
        #1;
        chk("s6_rst_req", RD_REQ, 1'b0);
        chk("s6_rst_busy", BUSY, 1'b0);
        chk("s6_rst_ready", TILE_READY, 1'b0);
        chk("s6_rst_sel", {FIFO_Write_Choose, FIFO_Read_Choose}, 2'b00);
        tick();
        RSTN_syncn = 1'b1;
        tick();
        chk("s6_inflight_err", ERR, 1'b0);
        RD_FIFO_WE = 1'b0;
        tick();
        do_start(32'h8000, 10'd1);
        chk("s6_busy", BUSY, 1'b1);
        tick();
        burst("s6_b0", 32'h8000, 1'b0);
        tick();
        reads(64);
        chk("s6_done", DONE, 1'b1);
        chk("s6_busy_off", BUSY, 1'b0);
        chk("s6_err", ERR, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
